dllp_rx_decode: RTL and testbench
=================================

Name: dllp_rx_decode

Overview:
- Receive-side Data Link Layer decoder. Consumes DLLPs delivered by the PHY de-framer as a 32-bit AXI-Stream and checks each DLLP's CRC16.
- Decodes Ack/Nak, InitFC1/InitFC2 and UpdateFC DLLPs for the configured VC.
- Directly feeds `dllp_transmit`: drives its `ack_nack_i`, `ack_nack_vld_i`, `ack_seq_num_i` and `tx_fc_*` inputs.

Parameters:
- DATA_WIDTH, 32, stream width; only 32 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 4, tuser width; bit 0 = PHY framing/symbol error.
- VC_ID, 0, virtual channel accepted for FC DLLPs (3 bits).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- s_axis_dllp_tdata_i  in  32  DLLP bytes; byte n on tdata[8n+7:8n].
- s_axis_dllp_tkeep_i  in  4  byte enables.
- s_axis_dllp_tvalid_i  in  1  beat valid.
- s_axis_dllp_tlast_i  in  1  last beat of DLLP.
- s_axis_dllp_tuser_i  in  USER_WIDTH  bit 0 = errored frame.
- s_axis_dllp_tready_o  out  1  always 1 out of reset.
- ack_nack_o  out  1  1 = Ack, 0 = Nak.
- ack_nack_vld_o  out  1  one-cycle strobe.
- ack_seq_num_o  out  12  AckNak_Seq_Num.
- tx_fc_ph_o, tx_fc_nph_o, tx_fc_cplh_o  out  8  header credit limits.
- tx_fc_pd_o, tx_fc_npd_o, tx_fc_cpld_o  out  12  data credit limits.
- fc_init1_done_o  out  1  InitFC1 received for P, NP and Cpl.
- fc_init2_done_o  out  1  InitFC2 (or UpdateFC) received after init1 done.
- crc_err_o  out  1  one-cycle strobe per dropped DLLP.

Behaviour:
- Frame format:
  - 6 bytes over 2 beats. Beat0 keep=1111 carries bytes 0–3. Beat1 keep=0011 with tlast carries CRC bytes 4–5.
  - CRC per PCIe Base Spec DLLP CRC: poly 100Bh, seed FFFFh over bytes 0–3, complemented, bit-mapped per spec into byte4/byte5.
- Decode, byte0:
  - 00h = Ack; 10h = Nak; seq = {byte2[3:0], byte3}.
  - InitFC1: 40h/50h/60h for P/NP/Cpl, low 3 bits = VC.
  - InitFC2: C0h/D0h/E0h for P/NP/Cpl, low 3 bits = VC.
  - UpdateFC: 80h/90h/A0h for P/NP/Cpl, low 3 bits = VC.
  - Hdr = {byte1[5:0], byte2[7:6]}; Data = {byte2[3:0], byte3}.
- FSM:
  - IDLE: beat0 with tlast=0 → BEAT1, latch bytes 0–3. Beat0 with tlast=1 → drop (malformed), stay IDLE.
  - BEAT1: beat with tlast=1 → CHECK. Beat with tlast=0 → DISCARD.
  - DISCARD: consume beats until tlast, then → IDLE.
  - CHECK (1 cycle): compare CRC and apply the decode, then → IDLE. A beat arriving during CHECK is accepted as beat0 of the next DLLP; the FSM must not lose it.
- Latency: outputs update/strobe exactly 1 cycle after the beat1 handshake, i.e. on the CHECK cycle's registered result.
- Drop rules:
  - Drop on CRC mismatch, any beat with tuser[0]=1, wrong keep, or malformed length.
  - A drop raises `crc_err_o` for 1 cycle; no other output changes.
  - Unknown types and FC DLLPs for VC≠VC_ID are silently ignored with no strobe.
- Ack/Nak: `ack_nack_vld_o` pulses 1 cycle with `ack_nack_o` and `ack_seq_num_o` valid. The seq value is held after the strobe.
- FC updates:
  - InitFC1, InitFC2 and UpdateFC all overwrite the matching hdr/data limit registers.
  - `fc_init1_done_o` sets once all three InitFC1 types (P/NP/Cpl) have been seen.
  - `fc_init2_done_o` sets on the first InitFC2 or UpdateFC after init1 is done.
  - Both flags are sticky until reset.
  - A value of 0 is passed through unchanged; 0 = infinite credit, interpreted downstream.
- Reset: FSM→IDLE; all limits, seq, flags and strobes = 0; tready=0 during reset, 1 from the first cycle after. Reset mid-DLLP discards the partial frame.
- Back-to-back DLLPs with tvalid continuously high are supported at full rate (2 cycles per DLLP).

Optional Feature:
- Macro: DLLP_RX_STATS_EN.
- When defined, adds three 16-bit saturating outputs:
  - `stat_crc_err_o`: CRC/tuser drops.
  - `stat_malformed_o`: length/keep errors.
  - `stat_dllp_ok_o`: good DLLPs of any type.
- Counters clear on reset and hold at FFFFh.
- When undefined, these ports and counters do not exist and core behaviour is identical.

Test Plan:
- Ack: bytes 00 00 07 FF + valid CRC → `ack_nack_vld_o`=1 for 1 cycle, `ack_nack_o`=1, `ack_seq_num_o`=7FFh; Nak 10 00 00 05 → `ack_nack_o`=0, seq=005h.
- Init sequence: InitFC1 P (Hdr=20h, Data=100h), NP (Hdr=10h, Data=0), Cpl (0, 0) → limits ph=20h, pd=100h, nph=10h, npd=0; `fc_init1_done_o`=1 only after the third DLLP. Then InitFC2 P → `fc_init2_done_o`=1.
- UpdateFC P (Hdr=FFh, Data=FFFh) → `tx_fc_ph_o`=FFh and `tx_fc_pd_o`=FFFh the cycle after beat1; same Ack with CRC byte4 flipped → `crc_err_o` pulse, seq unchanged.
- Malformed: 1-beat frame with tlast; 3-beat frame; tuser[0]=1 on a valid Ack → each dropped, no `ack_nack_vld_o`; the next good DLLP decodes correctly.
- Throughput/VC: 8 back-to-back Acks with seq 1..8 → 8 strobes with matching seq. UpdateFC for VC1 → ignored.
- Reset after beat0 of an Ack → no strobe; the following good Nak decodes; with DLLP_RX_STATS_EN defined, `stat_dllp_ok_o`=1 afterwards.

Source files
------------

// File: rtl/dllp_rx_decode.sv
// Receive-side DLLP decoder: CRC16 check, Ack/Nak and InitFC/UpdateFC credit decode for one VC.
// Optional macro DLLP_RX_STATS_EN adds saturating counters for CRC drops, malformed frames and good DLLPs.
module dllp_rx_decode #(
    parameter int         DATA_WIDTH = 32,
    parameter int         KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int         USER_WIDTH = 4,
    parameter logic [2:0] VC_ID      = 3'd0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_dllp_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_dllp_tkeep_i,
    input  logic                  s_axis_dllp_tvalid_i,
    input  logic                  s_axis_dllp_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_dllp_tuser_i,
    output logic                  s_axis_dllp_tready_o,
    output logic                  ack_nack_o,
    output logic                  ack_nack_vld_o,
    output logic [11:0]           ack_seq_num_o,
    output logic [7:0]            tx_fc_ph_o,
    output logic [7:0]            tx_fc_nph_o,
    output logic [7:0]            tx_fc_cplh_o,
    output logic [11:0]           tx_fc_pd_o,
    output logic [11:0]           tx_fc_npd_o,
    output logic [11:0]           tx_fc_cpld_o,
    output logic                  fc_init1_done_o,
    output logic                  fc_init2_done_o,
`ifdef DLLP_RX_STATS_EN
    output logic [15:0]           stat_crc_err_o,
    output logic [15:0]           stat_malformed_o,
    output logic [15:0]           stat_dllp_ok_o,
`endif
    output logic                  crc_err_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BEAT1   = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    // Serial CRC, bit 0 of byte 0 first, polynomial 100Bh, seed FFFFh.
    function automatic logic [15:0] dllp_crc16(input logic [31:0] bytes);
        logic [15:0] lfsr;
        logic        fb;
        lfsr = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb   = lfsr[15] ^ bytes[i];
            lfsr = {lfsr[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
        end
        return lfsr;
    endfunction

    logic [1:0]  state_reg, state_next;
    logic        tready_reg;
    logic [31:0] beat0_reg;
    logic        beat0_keep_bad_reg;
    logic        beat0_err_reg;

    logic        hs;
    logic        latch_beat0;
    logic        frame_done;
    logic        drop_len;

    assign hs = s_axis_dllp_tvalid_i & tready_reg;

    always_comb begin
        state_next  = state_reg;
        latch_beat0 = 1'b0;
        frame_done  = 1'b0;
        drop_len    = 1'b0;
        case (state_reg)
            // CHECK accepts a new beat0 exactly like IDLE so back-to-back DLLPs run at full rate.
            ST_IDLE, ST_CHECK: begin
                state_next = ST_IDLE;
                if (hs) begin
                    if (s_axis_dllp_tlast_i) begin
                        drop_len = 1'b1;
                    end else begin
                        latch_beat0 = 1'b1;
                        state_next  = ST_BEAT1;
                    end
                end
            end
            ST_BEAT1: begin
                if (hs) begin
                    if (s_axis_dllp_tlast_i) begin
                        frame_done = 1'b1;
                        state_next = ST_CHECK;
                    end else begin
                        state_next = ST_DISCARD;
                    end
                end
            end
            default: begin
                if (hs && s_axis_dllp_tlast_i) begin
                    drop_len   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg          <= ST_IDLE;
            tready_reg         <= 1'b0;
            beat0_reg          <= '0;
            beat0_keep_bad_reg <= 1'b0;
            beat0_err_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tready_reg <= 1'b1;
            if (latch_beat0) begin
                beat0_reg          <= s_axis_dllp_tdata_i[31:0];
                beat0_keep_bad_reg <= (s_axis_dllp_tkeep_i != 4'hF);
                beat0_err_reg      <= s_axis_dllp_tuser_i[0];
            end
        end
    end

    // Expected CRC field: complemented remainder, bit-reversed within each byte.
    logic [15:0] crc_inv;
    logic [15:0] crc_field;
    assign crc_inv = ~dllp_crc16(beat0_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_crc_map
            assign crc_field[gi]     = crc_inv[15-gi];
            assign crc_field[8+gi]   = crc_inv[7-gi];
        end
    endgenerate

    logic keep_bad;
    logic frame_err;
    logic crc_ok;
    logic drop_malformed;
    logic drop_crc;
    logic good;

    assign keep_bad       = beat0_keep_bad_reg | (s_axis_dllp_tkeep_i != 4'h3);
    assign frame_err      = beat0_err_reg | s_axis_dllp_tuser_i[0];
    assign crc_ok         = (s_axis_dllp_tdata_i[15:0] == crc_field);
    assign drop_malformed = drop_len | (frame_done & keep_bad);
    assign drop_crc       = frame_done & ~keep_bad & (frame_err | ~crc_ok);
    assign good           = frame_done & ~keep_bad & ~frame_err & crc_ok;

    logic [7:0] b0, b1, b2, b3;
    assign b0 = beat0_reg[7:0];
    assign b1 = beat0_reg[15:8];
    assign b2 = beat0_reg[23:16];
    assign b3 = beat0_reg[31:24];

    logic        is_ack, is_nak;
    logic        fc_hit;
    logic [1:0]  fc_sel;
    logic [1:0]  fc_phase;
    logic [7:0]  fc_hdr;
    logic [11:0] fc_data;

    assign is_ack   = (b0 == 8'h00);
    assign is_nak   = (b0 == 8'h10);
    // byte0[7:6]: 01 InitFC1, 11 InitFC2, 10 UpdateFC; byte0[5:4]: 0 P, 1 NP, 2 Cpl.
    assign fc_phase = b0[7:6];
    assign fc_sel   = b0[5:4];
    assign fc_hit   = (fc_phase != 2'b00) && (fc_sel != 2'b11) && !b0[3] && (b0[2:0] == VC_ID);
    assign fc_hdr   = {b1[5:0], b2[7:6]};
    assign fc_data  = {b2[3:0], b3};

    logic        fc_upd;
    logic        fc_is_init1;
    logic        fc_is_later;
    assign fc_upd      = good & fc_hit;
    assign fc_is_init1 = (fc_phase == 2'b01);
    assign fc_is_later = (fc_phase == 2'b11) || (fc_phase == 2'b10);

    logic [7:0]  hdr_lim  [3];
    logic [11:0] data_lim [3];
    logic [2:0]  init1_seen;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_fc_type
            logic [7:0]  hdr_reg;
            logic [11:0] data_reg;
            logic        seen_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    hdr_reg  <= '0;
                    data_reg <= '0;
                    seen_reg <= 1'b0;
                end else if (fc_upd && (fc_sel == 2'(gi))) begin
                    hdr_reg  <= fc_hdr;
                    data_reg <= fc_data;
                    if (fc_is_init1) begin
                        seen_reg <= 1'b1;
                    end
                end
            end
            assign hdr_lim[gi]    = hdr_reg;
            assign data_lim[gi]   = data_reg;
            assign init1_seen[gi] = seen_reg;
        end
    endgenerate

    logic        ack_vld_reg;
    logic        ack_reg;
    logic [11:0] seq_reg;
    logic        init2_done_reg;
    logic        crc_err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_vld_reg    <= 1'b0;
            ack_reg        <= 1'b0;
            seq_reg        <= '0;
            init2_done_reg <= 1'b0;
            crc_err_reg    <= 1'b0;
        end else begin
            ack_vld_reg <= good & (is_ack | is_nak);
            crc_err_reg <= drop_malformed | drop_crc;
            if (good && (is_ack || is_nak)) begin
                ack_reg <= is_ack;
                seq_reg <= {b2[3:0], b3};
            end
            if (fc_upd && fc_is_later && (&init1_seen)) begin
                init2_done_reg <= 1'b1;
            end
        end
    end

`ifdef DLLP_RX_STATS_EN
    logic [15:0] stat_crc_reg;
    logic [15:0] stat_mal_reg;
    logic [15:0] stat_ok_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_crc_reg <= '0;
            stat_mal_reg <= '0;
            stat_ok_reg  <= '0;
        end else begin
            if (drop_crc && (stat_crc_reg != 16'hFFFF)) begin
                stat_crc_reg <= stat_crc_reg + 16'd1;
            end
            if (drop_malformed && (stat_mal_reg != 16'hFFFF)) begin
                stat_mal_reg <= stat_mal_reg + 16'd1;
            end
            if (good && (stat_ok_reg != 16'hFFFF)) begin
                stat_ok_reg <= stat_ok_reg + 16'd1;
            end
        end
    end

    assign stat_crc_err_o   = stat_crc_reg;
    assign stat_malformed_o = stat_mal_reg;
    assign stat_dllp_ok_o   = stat_ok_reg;
`endif

    assign s_axis_dllp_tready_o = tready_reg;
    assign ack_nack_o           = ack_reg;
    assign ack_nack_vld_o       = ack_vld_reg;
    assign ack_seq_num_o        = seq_reg;
    assign tx_fc_ph_o           = hdr_lim[0];
    assign tx_fc_nph_o          = hdr_lim[1];
    assign tx_fc_cplh_o         = hdr_lim[2];
    assign tx_fc_pd_o           = data_lim[0];
    assign tx_fc_npd_o          = data_lim[1];
    assign tx_fc_cpld_o         = data_lim[2];
    assign fc_init1_done_o      = &init1_seen;
    assign fc_init2_done_o      = init2_done_reg;
    assign crc_err_o            = crc_err_reg;

    // Bits of the stream and reserved DLLP fields that carry nothing for this decoder.
    logic unused_bits;
    assign unused_bits = ^{s_axis_dllp_tdata_i[31:16], s_axis_dllp_tuser_i,
                           b1[7:6], b2[5:4]};

endmodule

// File: tb/tb_dllp_rx_decode.sv
// Directed self-checking bench for dllp_rx_decode: Ack/Nak, FC init/update, drops, throughput, reset.
module tb_dllp_rx_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic [3:0]  tuser;
    logic        tready;
    logic        ack_nack;
    logic        ack_nack_vld;
    logic [11:0] ack_seq_num;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;
    logic        init1_done, init2_done;
    logic        crc_err;
`ifdef DLLP_RX_STATS_EN
    logic [15:0] stat_crc, stat_mal, stat_ok;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dllp_rx_decode #(.VC_ID(3'd0)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .s_axis_dllp_tdata_i  (tdata),
        .s_axis_dllp_tkeep_i  (tkeep),
        .s_axis_dllp_tvalid_i (tvalid),
        .s_axis_dllp_tlast_i  (tlast),
        .s_axis_dllp_tuser_i  (tuser),
        .s_axis_dllp_tready_o (tready),
        .ack_nack_o           (ack_nack),
        .ack_nack_vld_o       (ack_nack_vld),
        .ack_seq_num_o        (ack_seq_num),
        .tx_fc_ph_o           (ph),
        .tx_fc_nph_o          (nph),
        .tx_fc_cplh_o         (cplh),
        .tx_fc_pd_o           (pd),
        .tx_fc_npd_o          (npd),
        .tx_fc_cpld_o         (cpld),
        .fc_init1_done_o      (init1_done),
        .fc_init2_done_o      (init2_done),
`ifdef DLLP_RX_STATS_EN
        .stat_crc_err_o       (stat_crc),
        .stat_malformed_o     (stat_mal),
        .stat_dllp_ok_o       (stat_ok),
`endif
        .crc_err_o            (crc_err)
    );

    function automatic logic [31:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [31:0] fc_word(input logic [7:0] b0, input logic [7:0] hdr,
                                            input logic [11:0] data);
        return mk(b0, {2'b00, hdr[7:2]}, {hdr[1:0], 2'b00, data[11:8]}, data[7:0]);
    endfunction

    // Reference CRC field {byte5, byte4} for bytes 0..3, computed serially bit 0 first.
    function automatic logic [15:0] crc_field(input logic [31:0] bytes);
        logic [15:0] lfsr;
        logic [15:0] inv;
        logic [7:0]  byte4, byte5;
        logic        din, top;
        lfsr = 16'hFFFF;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 8; k++) begin
                din  = bytes[8*n+k];
                top  = lfsr[15];
                lfsr = lfsr << 1;
                if (top ^ din) lfsr = lfsr ^ 16'h100B;
            end
        end
        inv = ~lfsr;
        for (int k = 0; k < 8; k++) begin
            byte4[k] = inv[15-k];
            byte5[k] = inv[7-k];
        end
        return {byte5, byte4};
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        @(negedge clk);
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tuser  = {3'b000, u};
        tvalid = 1'b1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 4'h0;
        tkeep  = 4'h0;
    endtask

    // Sends one two-beat DLLP; returns at the negedge where its result is visible.
    task automatic send_dllp(input logic [31:0] bytes, input logic bad_crc, input logic user_err);
        logic [15:0] crc;
        crc = crc_field(bytes);
        if (bad_crc) crc = crc ^ 16'h0001;
        $display("dllp bytes=%h crc=%h bad_crc=%0b tuser0=%0b", bytes, crc, bad_crc, user_err);
        drive_beat(bytes, 4'hF, 1'b0, user_err);
        drive_beat({16'h0000, crc}, 4'h3, 1'b1, 1'b0);
        go_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '0; tuser = '0;
        repeat (3) @(negedge clk);
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b expected 0", tready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL tready_after_reset: got %0b expected 1", tready); end
        checks++; if (ack_nack_vld !== 1'b0 || crc_err !== 1'b0) begin errors++; $display("FAIL reset_strobes: vld=%0b crc_err=%0b expected 0 0", ack_nack_vld, crc_err); end
        checks++; if ({ph, pd, ack_seq_num} !== 32'h0) begin errors++; $display("FAIL reset_regs: ph=%h pd=%h seq=%h expected 0", ph, pd, ack_seq_num); end
        checks++; if ({init1_done, init2_done} !== 2'b00) begin errors++; $display("FAIL reset_flags: %b expected 00", {init1_done, init2_done}); end
        $display("reset done");
    endtask

    task automatic test_ack_nak();
        send_dllp(mk(8'h00, 8'h00, 8'h07, 8'hFF), 1'b0, 1'b0);
        checks++; if (ack_nack_vld !== 1'b1) begin errors++; $display("FAIL ack_vld: got %0b expected 1", ack_nack_vld); end
        checks++; if (ack_nack !== 1'b1) begin errors++; $display("FAIL ack_type: got %0b expected 1", ack_nack); end
        checks++; if (ack_seq_num !== 12'h7FF) begin errors++; $display("FAIL ack_seq: got %h expected 7ff", ack_seq_num); end
        @(negedge clk);
        checks++; if (ack_nack_vld !== 1'b0) begin errors++; $display("FAIL ack_vld_one_cycle: got %0b expected 0", ack_nack_vld); end
        checks++; if (ack_seq_num !== 12'h7FF) begin errors++; $display("FAIL ack_seq_held: got %h expected 7ff", ack_seq_num); end
        send_dllp(mk(8'h10, 8'h00, 8'h00, 8'h05), 1'b0, 1'b0);
        checks++; if ({ack_nack_vld, ack_nack} !== 2'b10) begin errors++; $display("FAIL nak_type: vld,ack=%b expected 10", {ack_nack_vld, ack_nack}); end
        checks++; if (ack_seq_num !== 12'h005) begin errors++; $display("FAIL nak_seq: got %h expected 005", ack_seq_num); end
    endtask

    task automatic test_init_fc();
        // UpdateFC before init1 completes overwrites the limit but must not set init2.
        send_dllp(fc_word(8'h90, 8'h05, 12'h000), 1'b0, 1'b0);
        checks++; if (nph !== 8'h05) begin errors++; $display("FAIL early_update_nph: got %h expected 05", nph); end
        checks++; if (init2_done !== 1'b0) begin errors++; $display("FAIL early_init2: got %0b expected 0", init2_done); end
        send_dllp(fc_word(8'h40, 8'h20, 12'h100), 1'b0, 1'b0);
        send_dllp(fc_word(8'h50, 8'h10, 12'h000), 1'b0, 1'b0);
        checks++; if (init1_done !== 1'b0) begin errors++; $display("FAIL init1_early: got %0b expected 0", init1_done); end
        send_dllp(fc_word(8'h60, 8'h00, 12'h000), 1'b0, 1'b0);
        checks++; if (init1_done !== 1'b1) begin errors++; $display("FAIL init1_done: got %0b expected 1", init1_done); end
        checks++; if (ph !== 8'h20 || pd !== 12'h100) begin errors++; $display("FAIL init_p: ph=%h pd=%h expected 20 100", ph, pd); end
        checks++; if (nph !== 8'h10 || npd !== 12'h000) begin errors++; $display("FAIL init_np: nph=%h npd=%h expected 10 000", nph, npd); end
        checks++; if (cplh !== 8'h00 || cpld !== 12'h000) begin errors++; $display("FAIL init_cpl: cplh=%h cpld=%h expected 00 000", cplh, cpld); end
        checks++; if (init2_done !== 1'b0) begin errors++; $display("FAIL init2_before_fc2: got %0b expected 0", init2_done); end
        send_dllp(fc_word(8'hC0, 8'h20, 12'h100), 1'b0, 1'b0);
        checks++; if (init2_done !== 1'b1) begin errors++; $display("FAIL init2_done: got %0b expected 1", init2_done); end
    endtask

    task automatic test_update_fc();
        send_dllp(fc_word(8'h80, 8'hFF, 12'hFFF), 1'b0, 1'b0);
        checks++; if (ph !== 8'hFF || pd !== 12'hFFF) begin errors++; $display("FAIL update_p: ph=%h pd=%h expected ff fff", ph, pd); end
        checks++; if (ack_nack_vld !== 1'b0 || crc_err !== 1'b0) begin errors++; $display("FAIL update_no_strobe: vld=%0b crc_err=%0b expected 0 0", ack_nack_vld, crc_err); end
        send_dllp(mk(8'h00, 8'h00, 8'h07, 8'hFF), 1'b1, 1'b0);
        checks++; if (crc_err !== 1'b1 || ack_nack_vld !== 1'b0) begin errors++; $display("FAIL bad_crc_drop: crc_err=%0b vld=%0b expected 1 0", crc_err, ack_nack_vld); end
        checks++; if (ack_seq_num !== 12'h005) begin errors++; $display("FAIL bad_crc_seq: got %h expected 005", ack_seq_num); end
        @(negedge clk);
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL crc_err_one_cycle: got %0b expected 0", crc_err); end
    endtask

    task automatic test_malformed();
        logic [31:0] w;
        w = mk(8'h00, 8'h00, 8'h03, 8'h21);
        $display("dllp single beat with tlast");
        drive_beat(w, 4'hF, 1'b1, 1'b0);
        go_idle();
        checks++; if (crc_err !== 1'b1 || ack_nack_vld !== 1'b0) begin errors++; $display("FAIL one_beat_drop: crc_err=%0b vld=%0b expected 1 0", crc_err, ack_nack_vld); end
        $display("dllp three beats");
        drive_beat(w, 4'hF, 1'b0, 1'b0);
        drive_beat({16'h0000, crc_field(w)}, 4'h3, 1'b0, 1'b0);
        drive_beat(32'h0, 4'h3, 1'b1, 1'b0);
        checks++; if (ack_nack_vld !== 1'b0 || crc_err !== 1'b0) begin errors++; $display("FAIL three_beat_mid: vld=%0b crc_err=%0b expected 0 0", ack_nack_vld, crc_err); end
        go_idle();
        checks++; if (crc_err !== 1'b1 || ack_nack_vld !== 1'b0) begin errors++; $display("FAIL three_beat_drop: crc_err=%0b vld=%0b expected 1 0", crc_err, ack_nack_vld); end
        send_dllp(w, 1'b0, 1'b1);
        checks++; if (crc_err !== 1'b1 || ack_nack_vld !== 1'b0) begin errors++; $display("FAIL tuser_drop: crc_err=%0b vld=%0b expected 1 0", crc_err, ack_nack_vld); end
        $display("dllp wrong keep on beat1");
        drive_beat(w, 4'hF, 1'b0, 1'b0);
        drive_beat({16'h0000, crc_field(w)}, 4'hF, 1'b1, 1'b0);
        go_idle();
        checks++; if (crc_err !== 1'b1 || ack_nack_vld !== 1'b0) begin errors++; $display("FAIL keep_drop: crc_err=%0b vld=%0b expected 1 0", crc_err, ack_nack_vld); end
        checks++; if (ack_seq_num !== 12'h005) begin errors++; $display("FAIL drops_seq: got %h expected 005", ack_seq_num); end
        send_dllp(mk(8'h00, 8'h00, 8'h01, 8'h23), 1'b0, 1'b0);
        checks++; if (ack_nack_vld !== 1'b1 || ack_seq_num !== 12'h123 || crc_err !== 1'b0) begin errors++; $display("FAIL after_drop_ack: vld=%0b seq=%h crc_err=%0b expected 1 123 0", ack_nack_vld, ack_seq_num, crc_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int strobes;
        strobes = 0;
        for (int i = 1; i <= 8; i++) begin
            w = mk(8'h00, 8'h00, 8'h00, 8'(i));
            $display("dllp back-to-back seq=%0d", i);
            @(negedge clk);
            strobes += int'(ack_nack_vld);
            if (i > 1) begin
                checks++; if (ack_nack_vld !== 1'b1 || ack_seq_num !== 12'(i - 1)) begin errors++; $display("FAIL b2b_seq%0d: vld=%0b seq=%h expected 1 %h", i - 1, ack_nack_vld, ack_seq_num, 12'(i - 1)); end
            end
            tdata = w; tkeep = 4'hF; tlast = 1'b0; tuser = 4'h0; tvalid = 1'b1;
            @(negedge clk);
            strobes += int'(ack_nack_vld);
            tdata = {16'h0000, crc_field(w)}; tkeep = 4'h3; tlast = 1'b1;
        end
        go_idle();
        strobes += int'(ack_nack_vld);
        checks++; if (ack_nack_vld !== 1'b1 || ack_seq_num !== 12'h008) begin errors++; $display("FAIL b2b_seq8: vld=%0b seq=%h expected 1 008", ack_nack_vld, ack_seq_num); end
        checks++; if (strobes != 8) begin errors++; $display("FAIL b2b_count: got %0d strobes expected 8", strobes); end
    endtask

    task automatic test_vc_filter();
        send_dllp(fc_word(8'h81, 8'h00, 12'h000), 1'b0, 1'b0);
        checks++; if (ph !== 8'hFF || pd !== 12'hFFF) begin errors++; $display("FAIL vc1_ignored: ph=%h pd=%h expected ff fff", ph, pd); end
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL vc1_no_err: crc_err=%0b expected 0", crc_err); end
    endtask

    task automatic test_reset_mid_dllp();
        $display("dllp beat0 then reset");
        drive_beat(mk(8'h00, 8'h00, 8'h00, 8'hAA), 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ack_nack_vld !== 1'b0 || ack_seq_num !== 12'h000) begin errors++; $display("FAIL mid_reset_clear: vld=%0b seq=%h expected 0 000", ack_nack_vld, ack_seq_num); end
        checks++; if (ph !== 8'h00 || init1_done !== 1'b0 || init2_done !== 1'b0) begin errors++; $display("FAIL mid_reset_fc: ph=%h i1=%0b i2=%0b expected 00 0 0", ph, init1_done, init2_done); end
        send_dllp(mk(8'h10, 8'h00, 8'h00, 8'h3C), 1'b0, 1'b0);
        checks++; if (ack_nack_vld !== 1'b1 || ack_nack !== 1'b0 || ack_seq_num !== 12'h03C) begin errors++; $display("FAIL post_reset_nak: vld=%0b ack=%0b seq=%h expected 1 0 03c", ack_nack_vld, ack_nack, ack_seq_num); end
`ifdef DLLP_RX_STATS_EN
        checks++; if (stat_ok !== 16'd1 || stat_crc !== 16'd0 || stat_mal !== 16'd0) begin errors++; $display("FAIL stats: ok=%0d crc=%0d mal=%0d expected 1 0 0", stat_ok, stat_crc, stat_mal); end
`endif
    endtask

    initial begin
        test_reset();
        test_ack_nak();
        test_init_fc();
        test_update_fc();
        test_malformed();
        test_back_to_back();
        test_vc_filter();
        test_reset_mid_dllp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
